// File: rtl/agc_mct_scheduler.sv
// agc_mct_scheduler: memory-cycle scheduler for the AGC core.
// Generates time pulses 1..TP_LAST and, at every MCT boundary, picks the type of
// the next memory cycle (INSTR, counter CNT, interrupt RUPT, or the post-reset GOJAM).
// Optional feature macro: AGC_SINGLE_STEP_EN adds step_mode/step_req so the core
// can be single-stepped one instruction at a time.
//
// Request semantics: cnt_req/int_req/resume/step_req are single-clk pulses with no
// ready/acknowledge; a pulse is accepted unconditionally into its pending latch on
// the clk it is high, and its grant is visible only through cyc_type/cnt_sel/int_sel.
// cyc_type doubles as the exposed scheduler state.
module agc_mct_scheduler #(
  parameter int N_CNT   = 8,
  parameter int N_INT   = 5,
  parameter int TP_LAST = 12,
  localparam int TW = $clog2(TP_LAST + 1),
  localparam int CW = $clog2(N_CNT),
  localparam int IW = $clog2(N_INT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic [N_CNT-1:0] cnt_req,
  input  logic [N_INT-1:0] int_req,
  input  logic             int_inhibit,
  input  logic             inst_end,
  input  logic             resume,
`ifdef AGC_SINGLE_STEP_EN
  input  logic             step_mode,
  input  logic             step_req,
`endif
  output logic [TW-1:0]    tp,
  output logic             mct_end,
  output logic [1:0]       cyc_type,
  output logic [CW-1:0]    cnt_sel,
  output logic [IW-1:0]    int_sel,
  output logic             in_isr
);

  typedef enum logic [1:0] {
    CYC_INSTR = 2'b00,
    CYC_CNT   = 2'b01,
    CYC_RUPT  = 2'b10,
    CYC_GOJAM = 2'b11
  } cyc_t;

  cyc_t             cyc_q, cyc_d;
  logic [TW-1:0]    tp_d;
  logic [CW-1:0]    cnt_sel_d, cnt_idx;
  logic [IW-1:0]    int_sel_d, int_idx;
  logic [N_CNT-1:0] cnt_pend, cnt_pend_d, cnt_clr;
  logic [N_INT-1:0] int_pend, int_pend_d, int_clr;
  logic             cnt_any, int_any, isr_set, in_isr_d, hold, rupt_ok;

  assign cyc_type = cyc_q;

`ifdef AGC_SINGLE_STEP_EN
  logic step_arm;
  // Freeze at the end of a completed instruction until the operator steps.
  assign hold = step_mode && !step_arm && (tp == TW'(TP_LAST)) &&
                (cyc_q == CYC_INSTR) && inst_end;

  // A step pulse arms exactly one held boundary; taking any boundary disarms it.
  always_ff @(posedge clk) begin
    if (rst)           step_arm <= 1'b0;
    else if (step_req) step_arm <= 1'b1;
    else if (mct_end)  step_arm <= 1'b0;
  end
`else
  assign hold = 1'b0;
`endif

  // Boundary strobe is combinational so the boundary decision happens this clk.
  assign mct_end = adv && (tp == TW'(TP_LAST)) && !hold;

  // Lowest-index pending counter cell wins.
  always_comb begin
    cnt_any = 1'b0;
    cnt_idx = '0;
    for (int i = N_CNT - 1; i >= 0; i--) begin
      if (cnt_pend[i]) begin
        cnt_any = 1'b1;
        cnt_idx = CW'(i);
      end
    end
  end

  // Lowest-index pending interrupt source wins.
  always_comb begin
    int_any = 1'b0;
    int_idx = '0;
    for (int i = N_INT - 1; i >= 0; i--) begin
      if (int_pend[i]) begin
        int_any = 1'b1;
        int_idx = IW'(i);
      end
    end
  end

  // A RUPT may only interrupt between instructions, never nest, and never under INHINT.
  assign rupt_ok = int_any && !int_inhibit && !in_isr &&
                   (inst_end || (cyc_q != CYC_INSTR));

  // Next-state: time-pulse counter, boundary selection, pending and ISR bookkeeping.
  always_comb begin
    tp_d      = tp;
    cyc_d     = cyc_q;
    cnt_sel_d = cnt_sel;
    int_sel_d = int_sel;
    cnt_clr   = '0;
    int_clr   = '0;
    isr_set   = 1'b0;
    if (adv && !hold) begin
      tp_d = (tp == TW'(TP_LAST)) ? TW'(1) : tp + TW'(1);
    end
    if (mct_end) begin
      if (cnt_any) begin
        cyc_d            = CYC_CNT;
        cnt_sel_d        = cnt_idx;
        cnt_clr[cnt_idx] = 1'b1;
      end else if (rupt_ok) begin
        cyc_d            = CYC_RUPT;
        int_sel_d        = int_idx;
        int_clr[int_idx] = 1'b1;
        isr_set          = 1'b1;
      end else begin
        cyc_d = CYC_INSTR;
      end
    end
    // A request arriving on its own grant clk survives the clear.
    cnt_pend_d = (cnt_pend & ~cnt_clr) | cnt_req;
    int_pend_d = (int_pend & ~int_clr) | int_req;
    in_isr_d   = isr_set ? 1'b1 : (resume ? 1'b0 : in_isr);
  end

  // State registers; reset at any time point abandons the current MCT.
  always_ff @(posedge clk) begin
    if (rst) begin
      tp       <= TW'(1);
      cyc_q    <= CYC_GOJAM;
      cnt_sel  <= '0;
      int_sel  <= '0;
      in_isr   <= 1'b0;
      cnt_pend <= '0;
      int_pend <= '0;
    end else begin
      tp       <= tp_d;
      cyc_q    <= cyc_d;
      cnt_sel  <= cnt_sel_d;
      int_sel  <= int_sel_d;
      in_isr   <= in_isr_d;
      cnt_pend <= cnt_pend_d;
      int_pend <= int_pend_d;
    end
  end

endmodule
